// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_pkg
//  Description : Shared constants and types for the FFT frame loader:
//                frame size, sample width/format, sample type and the
//                loader state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    localparam int FFT_N     = 16;  // samples per frame
    localparam int SAMPLE_W  = 16;  // signed Q8.8 sample width
    localparam int FRAC_BITS = 8;   // fractional bits of a sample

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    // FILL: collecting samples; HOLD: frame frozen while the FFT computes.
    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage : fft_pkg
`default_nettype wire

// File: rtl/fft_lat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : fft_lat_counter
//  Description : Loadable count-down timer for the HOLD phase. 'load' writes
//                load_val; the counter then decrements to 0 and stops.
//                'done' marks the last cycle of the interval (count == 1).
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                load          - load load_val this edge
//                load_val[7:0] - interval length in cycles (1..255)
//                done          - final cycle of the loaded interval
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_lat_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != 8'd0) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Loaded value L gives L cycles of count L..1; the cycle at 1 is the last.
    assign done = (count_q == 8'd1);

endmodule : fft_lat_counter
`default_nettype wire

// File: rtl/fft_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : fft_frame_loader
//  Description : Collects N complex samples into a parallel lane buffer,
//                then holds the frame stable for FFT_LATENCY cycles while a
//                downstream combinational/pipelined FFT computes, pulsing
//                result_valid in the last hold cycle.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                s_valid/s_ready    - sample handshake
//                s_real/s_im        - sample real/imag part (Q8.8)
//                flush              - drop the partially filled frame
//                frame_real/im      - lane k at [k*W +: W]
//                frame_valid        - frame complete and stable
//                result_valid       - FFT outputs valid this cycle
//                fill_count         - samples in the current frame (0..N)
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_frame_loader
    import fft_pkg::*;
#(
    parameter int N           = FFT_N,
    parameter int W           = SAMPLE_W,
    parameter int FFT_LATENCY = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_valid,
    output logic           s_ready,
    input  logic [W-1:0]   s_real,
    input  logic [W-1:0]   s_im,
    input  logic           flush,
    output logic [N*W-1:0] frame_real,
    output logic [N*W-1:0] frame_im,
    output logic           frame_valid,
    output logic           result_valid,
    output logic [4:0]     fill_count
);

    localparam logic [4:0] C_LAST = 5'(N - 1);
    localparam logic [4:0] C_FULL = 5'(N);

    state_t       state_q, state_d;
    logic [4:0]   fill_q, fill_d;
    logic [W-1:0] lane_real_q [N];
    logic [W-1:0] lane_real_d [N];
    logic [W-1:0] lane_im_q   [N];
    logic [W-1:0] lane_im_d   [N];
    logic         lat_load;
    logic         lat_done;
    logic         accept;

    // flush wins over a sample presented in the same FILL cycle.
    assign accept = (state_q == FILL) && s_valid && !flush;

    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        lat_load = 1'b0;
        for (int k = 0; k < N; k++) begin
            lane_real_d[k] = lane_real_q[k];
            lane_im_d[k]   = lane_im_q[k];
        end

        case (state_q)
            FILL: begin
                if (flush) begin
                    fill_d = 5'd0;
                end else if (accept) begin
                    for (int k = 0; k < N; k++) begin
                        if (fill_q == 5'(k)) begin
                            lane_real_d[k] = s_real;
                            lane_im_d[k]   = s_im;
                        end
                    end
                    if (fill_q == C_LAST) begin
                        fill_d   = C_FULL;
                        state_d  = HOLD;
                        lat_load = 1'b1;
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
            end
            HOLD: begin
                // Lanes frozen; inputs and flush ignored until the timer ends.
                if (lat_done) begin
                    state_d = FILL;
                    fill_d  = 5'd0;
                end
            end
            default: begin
                state_d = FILL;
                fill_d  = 5'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            fill_q  <= 5'd0;
            for (int k = 0; k < N; k++) begin
                lane_real_q[k] <= '0;
                lane_im_q[k]   <= '0;
            end
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            for (int k = 0; k < N; k++) begin
                lane_real_q[k] <= lane_real_d[k];
                lane_im_q[k]   <= lane_im_d[k];
            end
        end
    end

    fft_lat_counter u_lat_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (lat_load),
        .load_val (8'(FFT_LATENCY)),
        .done     (lat_done)
    );

    generate
        for (genvar k = 0; k < N; k++) begin : g_lane_pack
            assign frame_real[k*W +: W] = lane_real_q[k];
            assign frame_im[k*W +: W]   = lane_im_q[k];
        end
    endgenerate

    // rst gating keeps s_ready low during reset and suppresses a result
    // pulse for a held frame that the reset is about to discard.
    assign s_ready      = (state_q == FILL) && !rst;
    assign frame_valid  = (state_q == HOLD);
    assign result_valid = (state_q == HOLD) && lat_done && !rst;
    assign fill_count   = fill_q;

endmodule : fft_frame_loader
`default_nettype wire

// File: tb/tb_fft_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_frame_loader
//  Description : Self-checking bench for fft_frame_loader. A vector table
//                covers the gap-free ramp and backpressure during HOLD;
//                directed sequences cover flush, gapped input, reset in
//                HOLD and a FFT_LATENCY=1 instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_frame_loader;

    localparam int N  = 16;
    localparam int W  = 16;
    localparam int NW = N * W;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0, flush = 1'b0;
    logic [W-1:0]  s_real = '0, s_im = '0;
    logic          s_ready, frame_valid, result_valid;
    logic [NW-1:0] frame_real, frame_im;
    logic [4:0]    fill_count;

    logic          s_valid2 = 1'b0, flush2 = 1'b0;
    logic [W-1:0]  s_real2 = '0, s_im2 = '0;
    logic          s_ready2, frame_valid2, result_valid2;
    logic [NW-1:0] frame_real2, frame_im2;
    logic [4:0]    fill_count2;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fft_frame_loader #(.N(N), .W(W), .FFT_LATENCY(4)) dut (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
        .s_real(s_real), .s_im(s_im), .flush(flush),
        .frame_real(frame_real), .frame_im(frame_im),
        .frame_valid(frame_valid), .result_valid(result_valid),
        .fill_count(fill_count)
    );

    fft_frame_loader #(.N(N), .W(W), .FFT_LATENCY(1)) dut_l1 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(s_ready2),
        .s_real(s_real2), .s_im(s_im2), .flush(flush2),
        .frame_real(frame_real2), .frame_im(frame_im2),
        .frame_valid(frame_valid2), .result_valid(result_valid2),
        .fill_count(fill_count2)
    );

    typedef struct {
        logic         v;
        logic [W-1:0] re;
        logic         rdy;
        logic [4:0]   fill;
        logic         fv;
        logic         rv;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string nm, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle's inputs at the falling edge; outputs are then stable
    // for the current cycle and can be checked right after.
    task automatic drive(input logic v, input logic f, input logic [W-1:0] re, input logic [W-1:0] im);
        @(negedge clk);
        s_valid = v;
        flush   = f;
        s_real  = re;
        s_im    = im;
        #1;
    endtask

    logic [NW-1:0] ramp, gap_im, all_ff00;
    int            acc, hc;
    logic          found;

    initial begin
        for (int k = 0; k < N; k++) begin
            ramp[k*W +: W]     = 16'(k * 256);
            gap_im[k*W +: W]   = 16'(k);
            all_ff00[k*W +: W] = 16'hFF00;
        end
        for (int k = 0; k < 16; k++)
            tbl[k] = '{v: 1'b1, re: 16'(k * 256), rdy: 1'b1, fill: 5'(k), fv: 1'b0, rv: 1'b0};
        for (int k = 16; k < 20; k++)
            tbl[k] = '{v: 1'b1, re: 16'h7FFF, rdy: 1'b0, fill: 5'd16, fv: 1'b1, rv: (k == 19)};
        tbl[20] = '{v: 1'b1, re: 16'h1234, rdy: 1'b1, fill: 5'd0, fv: 1'b0, rv: 1'b0};

        // ---------------- reset ----------------
        rst = 1'b1;
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        drive(1, 1, 16'h5A5A, 0);
        chk("rst_ready", NW'(s_ready), NW'(0));
        chk("rst_fill", NW'(fill_count), NW'(0));
        chk("rst_fv", NW'(frame_valid), NW'(0));
        chk("rst_rv", NW'(result_valid), NW'(0));
        chk("rst_real", frame_real, '0);
        chk("rst_im", frame_im, '0);
        chk("rst_l1_real", frame_real2, '0);
        @(negedge clk);
        rst = 1'b0;
        s_valid = 0; flush = 0;
        #1;
        chk("rel_ready", NW'(s_ready), NW'(1));
        chk("rel_l1_ready", NW'(s_ready2), NW'(1));

        // ---------------- ramp + backpressure table ----------------
        for (int i = 0; i < 21; i++) begin
            drive(tbl[i].v, 0, tbl[i].re, 0);
            chk($sformatf("tbl%0d_ready", i), NW'(s_ready), NW'(tbl[i].rdy));
            chk($sformatf("tbl%0d_fill", i), NW'(fill_count), NW'(tbl[i].fill));
            chk($sformatf("tbl%0d_fv", i), NW'(frame_valid), NW'(tbl[i].fv));
            chk($sformatf("tbl%0d_rv", i), NW'(result_valid), NW'(tbl[i].rv));
            if (i == 16 || i == 19) begin
                chk($sformatf("tbl%0d_real", i), frame_real, ramp);
                chk($sformatf("tbl%0d_im", i), frame_im, '0);
            end
        end
        drive(0, 0, 0, 0);
        chk("post_hold_fill", NW'(fill_count), NW'(1));
        chk("post_hold_lane0", NW'(frame_real[0 +: W]), NW'(16'h1234));
        chk("post_hold_lane1", NW'(frame_real[W +: W]), NW'(16'h0100));

        // ---------------- flush ----------------
        for (int k = 1; k < 7; k++) drive(1, 0, 16'(k * 256), 0);
        drive(1, 1, 16'h0100, 0);
        chk("flush_fill_before", NW'(fill_count), NW'(7));
        drive(1, 0, 16'hABCD, 0);
        chk("flush_fill_after", NW'(fill_count), NW'(0));
        drive(0, 1, 0, 0);
        chk("flush_next_fill", NW'(fill_count), NW'(1));
        chk("flush_lane0", NW'(frame_real[0 +: W]), NW'(16'hABCD));
        chk("flush_lane7", NW'(frame_real[7*W +: W]), NW'(16'h0700));

        // ---------------- gapped input ----------------
        acc = 0;
        for (int c = 0; c < 40 && acc < 16; c++) begin
            if (c % 2 == 0) drive(1, 0, 16'(acc * 256), 16'(acc));
            else            drive(0, 0, 16'h5555, 16'h5555);
            chk($sformatf("gap_fill_c%0d", c), NW'(fill_count), NW'(acc));
            if (c % 2 == 0) acc++;
        end
        hc = 0;
        found = 1'b0;
        for (int c = 0; c < 8 && !found; c++) begin
            drive(1, 1, 16'h7FFF, 16'h7FFF);
            if (c == 0) begin
                chk("gap_real", frame_real, ramp);
                chk("gap_im", frame_im, gap_im);
            end
            if (frame_valid) hc++;
            if (result_valid) begin
                found = 1'b1;
                chk("gap_rv_cycle", NW'(hc), NW'(4));
            end
        end
        if (!found) chk("gap_rv_seen", NW'(0), NW'(1));
        drive(0, 0, 0, 0);
        chk("gap_ready_back", NW'(s_ready), NW'(1));
        chk("gap_fill_back", NW'(fill_count), NW'(0));

        // ---------------- reset during HOLD ----------------
        for (int k = 0; k < 16; k++) drive(1, 0, 16'h0F0F, 16'h0F0F);
        drive(0, 0, 0, 0);
        chk("rh_fv_c1", NW'(frame_valid), NW'(1));
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rh_rv_c2", NW'(result_valid), NW'(0));
        chk("rh_ready_c2", NW'(s_ready), NW'(0));
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rh_fv", NW'(frame_valid), NW'(0));
        chk("rh_fill", NW'(fill_count), NW'(0));
        chk("rh_real", frame_real, '0);
        chk("rh_im", frame_im, '0);
        chk("rh_ready", NW'(s_ready), NW'(1));
        for (int c = 0; c < 4; c++) begin
            drive(0, 0, 0, 0);
            chk($sformatf("rh_no_rv_%0d", c), NW'(result_valid), NW'(0));
        end

        // ---------------- FFT_LATENCY = 1 ----------------
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            s_valid2 = 1'b1;
            s_real2  = 16'hFF00;
            s_im2    = 16'hFF00;
            #1;
            chk($sformatf("l1_ready_%0d", k), NW'(s_ready2), NW'(1));
        end
        @(negedge clk);
        s_valid2 = 1'b0;
        #1;
        chk("l1_fv", NW'(frame_valid2), NW'(1));
        chk("l1_rv", NW'(result_valid2), NW'(1));
        chk("l1_real", frame_real2, all_ff00);
        chk("l1_im", frame_im2, all_ff00);
        @(negedge clk);
        #1;
        chk("l1_fv_after", NW'(frame_valid2), NW'(0));
        chk("l1_rv_after", NW'(result_valid2), NW'(0));
        chk("l1_ready_after", NW'(s_ready2), NW'(1));
        chk("l1_fill_after", NW'(fill_count2), NW'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_fft_frame_loader
`default_nettype wire
